// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the synchronous FIFO:
//   - read-mode constants selecting standard or first-word-fall-through reads
//   - width helpers for address and occupancy-count vectors
//   - explicit wrap-increment for pointers over an arbitrary depth
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Address width: enough bits to index slots 0..depth-1.
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Count width: enough bits to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer advance with an explicit wrap, so depths that are not a power
  // of two work without mask arithmetic.
  function automatic int unsigned wrap_inc(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// DATA_WIDTH x FIFO_DEPTH storage array for sync_fifo_ctrl.
// One synchronous write port and one combinational read port; no reset on the
// array contents.
// Ports:
//   clk        in   write clock (rising edge)
//   wr_en_i    in   write strobe
//   wr_addr_i  in   write slot
//   wr_data_i  in   write word
//   rd_addr_i  in   read slot
//   rd_data_o  out  word currently stored at rd_addr_i
// -----------------------------------------------------------------------------
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int ADDR_W    = addr_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
// Single-clock FIFO with arbitrary depth, selectable standard / first-word-
// fall-through read mode, almost-full/almost-empty thresholds, occupancy count
// and sticky overflow/underflow flags.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   wr_en, din               write request and data
//   rd_en                    read request (standard) / pop (FWFT)
//   dout, dout_valid         read data and its qualifier
//   full, empty              occupancy status
//   almost_full/_empty       threshold status (count >= AF_THRESH /
//                            count <= AE_THRESH)
//   count                    words held, including the FWFT output word
//   err_clr                  clears the sticky error flags
//   overflow, underflow      sticky error flags
// -----------------------------------------------------------------------------
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int CNT_W     = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int              ADDR_W  = addr_width(FIFO_DEPTH);
  localparam bit              IS_FWFT = (FWFT == FIFO_MODE_FWFT);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]     wr_ptr_inc, rd_ptr_inc, mem_rd_addr;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d, mem_rd_data;
  logic                  dout_valid_q, dout_valid_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  full_w, empty_w, wr_acc, rd_acc;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);
  assign wr_acc  = wr_en && !full_w;
  assign rd_acc  = rd_en && !empty_w;

  assign wr_ptr_inc = ADDR_W'(wrap_inc(32'(wr_ptr_q), FIFO_DEPTH));
  assign rd_ptr_inc = ADDR_W'(wrap_inc(32'(rd_ptr_q), FIFO_DEPTH));

  // In FWFT mode the head word already sits in dout_q, so the array is read
  // one slot ahead to have the successor ready when the head is popped.
  assign mem_rd_addr = IS_FWFT ? rd_ptr_inc : rd_ptr_q;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (din),
    .rd_addr_i (mem_rd_addr),
    .rd_data_o (mem_rd_data)
  );

  always_comb begin
    wr_ptr_d     = wr_acc ? wr_ptr_inc : wr_ptr_q;
    rd_ptr_d     = rd_acc ? rd_ptr_inc : rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    if (wr_acc && !rd_acc) begin
      count_d = count_q + ONE_C;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - ONE_C;
    end

    if (IS_FWFT) begin
      if (empty_w) begin
        // Write into an empty FIFO goes straight to the output register.
        if (wr_acc) dout_d = din;
      end else if (rd_acc) begin
        if (count_q != ONE_C) begin
          dout_d = mem_rd_data;
        end else if (wr_acc) begin
          // Last word popped while a new one arrives: bypass the array,
          // whose slot is only being written at this edge.
          dout_d = din;
        end
      end
    end else if (rd_acc) begin
      dout_d       = mem_rd_data;
      dout_valid_d = 1'b1;
    end

    // A new violation takes priority over a clear in the same cycle.
    ovf_d = (wr_en && full_w)  ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    unf_d = (rd_en && empty_w) ? 1'b1 : (err_clr ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = IS_FWFT ? !empty_w : dout_valid_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
// Three FIFO instances share one stimulus stream: standard depth 16, standard
// depth 5, FWFT depth 16. A queue-based model per instance predicts every
// output after each edge; a table and short directed sequences add explicit
// expectations for the named corner cases.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ctrl;

  logic       clk, rst, wr_en, rd_en, err_clr;
  logic [7:0] din;

  logic [7:0] s_dout, d_dout, f_dout;
  logic       s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       d_dv, d_full, d_empty, d_af, d_ae, d_ovf, d_unf;
  logic       f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] s_count, f_count;
  logic [2:0] d_count;

  sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .dout_valid(s_dv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .err_clr(err_clr), .overflow(s_ovf), .underflow(s_unf));

  sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(0)) u_d5 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(d_dout), .dout_valid(d_dv), .full(d_full), .empty(d_empty),
    .almost_full(d_af), .almost_empty(d_ae), .count(d_count),
    .err_clr(err_clr), .overflow(d_ovf), .underflow(d_unf));

  sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .err_clr(err_clr), .overflow(f_ovf), .underflow(f_unf));

  // Uniform views of the three instances.
  logic [7:0] o_dout [3];
  logic [7:0] o_count[3];
  logic       o_dv[3], o_full[3], o_empty[3], o_af[3], o_ae[3], o_ovf[3], o_unf[3];

  assign o_dout[0] = s_dout;  assign o_dout[1] = d_dout;  assign o_dout[2] = f_dout;
  assign o_count[0] = 8'(s_count); assign o_count[1] = 8'(d_count); assign o_count[2] = 8'(f_count);
  assign o_dv[0] = s_dv;      assign o_dv[1] = d_dv;      assign o_dv[2] = f_dv;
  assign o_full[0] = s_full;  assign o_full[1] = d_full;  assign o_full[2] = f_full;
  assign o_empty[0] = s_empty; assign o_empty[1] = d_empty; assign o_empty[2] = f_empty;
  assign o_af[0] = s_af;      assign o_af[1] = d_af;      assign o_af[2] = f_af;
  assign o_ae[0] = s_ae;      assign o_ae[1] = d_ae;      assign o_ae[2] = f_ae;
  assign o_ovf[0] = s_ovf;    assign o_ovf[1] = d_ovf;    assign o_ovf[2] = f_ovf;
  assign o_unf[0] = s_unf;    assign o_unf[1] = d_unf;    assign o_unf[2] = f_unf;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int dep_of(input int i);
    return (i == 1) ? 5 : 16;
  endfunction

  function automatic bit fw_of(input int i);
    return (i == 2);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: plain queue of stored words ----------
  logic [7:0] mq[3][$];
  logic [7:0] mdout[3];
  bit         mdv[3], movf[3], munf[3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mdout[i] = 8'h00;
      mdv[i]   = 1'b0;
      movf[i]  = 1'b0;
      munf[i]  = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int         sz;
      bit         mfull, mempty;
      logic [7:0] head;
      sz     = mq[i].size();
      mfull  = (sz == dep_of(i));
      mempty = (sz == 0);
      if (wr_en && mfull) movf[i] = 1'b1; else if (err_clr) movf[i] = 1'b0;
      if (rd_en && mempty) munf[i] = 1'b1; else if (err_clr) munf[i] = 1'b0;
      mdv[i] = 1'b0;
      if (rd_en && !mempty) begin
        head = mq[i].pop_front();
        if (!fw_of(i)) begin
          mdout[i] = head;
          mdv[i]   = 1'b1;
        end
      end
      if (wr_en && !mfull) mq[i].push_back(din);
      if (fw_of(i) && mq[i].size() > 0) mdout[i] = mq[i][0];
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 3; i++) begin
      int sz;
      sz = mq[i].size();
      chk($sformatf("%s.u%0d.count", tag, i), o_count[i], sz);
      chk($sformatf("%s.u%0d.full", tag, i), o_full[i], sz == dep_of(i));
      chk($sformatf("%s.u%0d.empty", tag, i), o_empty[i], sz == 0);
      chk($sformatf("%s.u%0d.afull", tag, i), o_af[i], sz >= dep_of(i) - 2);
      chk($sformatf("%s.u%0d.aempty", tag, i), o_ae[i], sz <= 2);
      chk($sformatf("%s.u%0d.ovf", tag, i), o_ovf[i], movf[i]);
      chk($sformatf("%s.u%0d.unf", tag, i), o_unf[i], munf[i]);
      chk($sformatf("%s.u%0d.dvalid", tag, i), o_dv[i], fw_of(i) ? (sz > 0) : mdv[i]);
      if (!fw_of(i) || sz > 0)
        chk($sformatf("%s.u%0d.dout", tag, i), o_dout[i], mdout[i]);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic w, input logic r, input logic c, input logic [7:0] d);
    wr_en = w; rd_en = r; err_clr = c; din = d;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 8'h00);
    rst = 1'b1;
    model_reset();
    #1;
    check_model("reset");
    rst = 1'b0;
  endtask

  // ---------------- table of vectors for the depth-16 standard instance ---
  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] din;
    int         cnt;
    logic [7:0] dout;
    logic       dv, ovf, unf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic w, input logic r, input logic c, input logic [7:0] d,
                     input int cnt, input logic [7:0] dout, input logic dv,
                     input logic ovf, input logic unf);
    vec_t v;
    v.wr = w; v.rd = r; v.clr = c; v.din = d; v.cnt = cnt;
    v.dout = dout; v.dv = dv; v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 8'h00);
    model_reset();
    #3;
    check_model("por");
    chk("por.fwft_dout", o_dout[2], 0);
    rst = 1'b0;

    // Fill 0x01..0x10, then full write+read, then drain, then error cases.
    for (int k = 1; k <= 16; k++) add(1, 0, 0, 8'(k), k, 8'h00, 0, 0, 0);
    add(1, 1, 0, 8'hEE, 15, 8'h01, 1, 1, 0);
    for (int j = 2; j <= 16; j++) add(0, 1, 0, 8'h00, 16 - j, 8'(j), 1, 1, 0);
    add(0, 0, 1, 8'h00, 0, 8'h10, 0, 0, 0);
    add(1, 1, 0, 8'h77, 1, 8'h10, 0, 0, 1);
    add(0, 1, 0, 8'h00, 0, 8'h77, 1, 0, 1);
    add(0, 1, 1, 8'h00, 0, 8'h77, 0, 0, 1);
    add(0, 0, 1, 8'h00, 0, 8'h77, 0, 0, 0);

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].wr, tbl[r].rd, tbl[r].clr, tbl[r].din);
      tick($sformatf("tbl%0d", r));
      chk($sformatf("tbl%0d.count", r), o_count[0], tbl[r].cnt);
      chk($sformatf("tbl%0d.full", r), o_full[0], tbl[r].cnt == 16);
      chk($sformatf("tbl%0d.empty", r), o_empty[0], tbl[r].cnt == 0);
      chk($sformatf("tbl%0d.afull", r), o_af[0], tbl[r].cnt >= 14);
      chk($sformatf("tbl%0d.aempty", r), o_ae[0], tbl[r].cnt <= 2);
      chk($sformatf("tbl%0d.dout", r), o_dout[0], tbl[r].dout);
      chk($sformatf("tbl%0d.dvalid", r), o_dv[0], tbl[r].dv);
      chk($sformatf("tbl%0d.ovf", r), o_ovf[0], tbl[r].ovf);
      chk($sformatf("tbl%0d.unf", r), o_unf[0], tbl[r].unf);
    end

    // FWFT: single write appears without rd_en, then back-to-back pops.
    do_reset();
    drive(1, 0, 0, 8'hA5);
    tick("fw_first");
    chk("fw_first.dout", o_dout[2], 8'hA5);
    chk("fw_first.empty", o_empty[2], 0);
    chk("fw_first.dvalid", o_dv[2], 1);
    drive(1, 0, 0, 8'hB1); tick("fw_w1");
    drive(1, 0, 0, 8'hB2); tick("fw_w2");
    drive(0, 1, 0, 8'h00); tick("fw_pop1");
    chk("fw_pop1.dout", o_dout[2], 8'hB1);
    tick("fw_pop2");
    chk("fw_pop2.dout", o_dout[2], 8'hB2);
    chk("fw_pop2.count", o_count[2], 1);
    tick("fw_pop3");
    chk("fw_pop3.empty", o_empty[2], 1);

    // Depth 5: steady write+read stream across the pointer wrap.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 8'(8'h80 + k)); tick("d5_fill");
    end
    for (int k = 0; k < 12; k++) begin
      drive(1, 1, 0, 8'(8'h90 + k)); tick("d5_stream");
      chk("d5_stream.count", o_count[1], 3);
      chk("d5_stream.dout", o_dout[1], (k < 3) ? (8'h80 + k) : (8'h90 + k - 3));
    end
    // Fill to 5, overflow, then clear together with a fresh overflow.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 8'(8'hC0 + k)); tick("d5_over");
    end
    chk("d5_over.count", o_count[1], 5);
    chk("d5_over.ovf", o_ovf[1], 1);
    drive(1, 0, 1, 8'hCC); tick("d5_clr_set");
    chk("d5_clr_set.ovf", o_ovf[1], 1);
    drive(0, 0, 1, 8'h00); tick("d5_clr");
    chk("d5_clr.ovf", o_ovf[1], 0);

    // Asynchronous reset with 7 words queued, then reuse.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(1, 0, 0, 8'(8'h40 + k)); tick("rst_fill");
    end
    chk("rst_fill.count", o_count[0], 7);
    drive(0, 0, 0, 8'h00);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mid.count", o_count[0], 0);
    chk("rst_mid.empty", o_empty[0], 1);
    chk("rst_mid.dout", o_dout[0], 0);
    chk("rst_mid.fwft_dout", o_dout[2], 0);
    chk("rst_mid.fwft_count", o_count[2], 0);
    rst = 1'b0;
    drive(1, 0, 0, 8'h3C); tick("rst_w");
    chk("rst_w.fwft_dout", o_dout[2], 8'h3C);
    drive(0, 1, 0, 8'h00); tick("rst_r");
    chk("rst_r.dout", o_dout[0], 8'h3C);
    chk("rst_r.dvalid", o_dv[0], 1);

    // Randomised traffic alternating between fill-biased and drain-biased.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bit fillphase;
      fillphase = ((c / 150) % 2) == 0;
      drive($urandom_range(0, 99) < (fillphase ? 75 : 30),
            $urandom_range(0, 99) < (fillphase ? 30 : 75),
            $urandom_range(0, 31) == 0,
            8'($urandom_range(0, 255)));
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
